// File: rtl/calc_arb_pkg.sv
// Shared types and helpers for the calc_arbiter block: FSM states and the
// round-robin winner search used by the RTL and by the bench model.
package calc_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int NREQ_DEF = 4;
    localparam int NREQ_MAX = 8;

    // First set bit strictly after 'last', wrapping mod nreq; returns 'last' when none set.
    function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                           input logic [2:0]          last,
                                           input int                  nreq);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ_MAX; k++) begin
            idx = (int'(last) + k) % nreq;
            if (k <= nreq && !found && valid[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/calc_arbiter_calc.sv
// Shared CALC datapath: registers I0-I1 (or I0+I1 when SUM is defined) every
// cycle, resetting O to 'init' through its own asynchronous reset.
module calc #(
    parameter int wd   = 8,
    parameter int init = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [wd-1:0] I0,
    input  logic [wd-1:0] I1,
    output logic [wd-1:0] O
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            O <= wd'(init);
        end else begin
`ifdef SUM
            O <= I0 + I1;
`else
            O <= I0 - I1;
`endif
        end
    end

endmodule

// File: rtl/calc_arbiter.sv
// Round-robin arbiter sharing one CALC between NREQ requesters; one request
// in flight at a time via an IDLE -> EXEC -> RESP sequence.
module calc_arbiter
    import calc_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int wd   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*wd-1:0]       req_a,
    input  logic [NREQ*wd-1:0]       req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [wd-1:0]            rsp_data,
    input  logic                     rsp_ready,
    output logic                     busy
);

    localparam int IDW = $clog2(NREQ);

    arb_state_t     r_state;
    arb_state_t     w_next;
    logic [IDW-1:0] r_last;
    logic [IDW-1:0] r_rsp_id;
    logic [wd-1:0]  r_op_a;
    logic [wd-1:0]  r_op_b;
    logic [wd-1:0]  w_calc_o;
    logic [IDW-1:0] w_win;
    logic           w_grant;
    logic [wd-1:0]  w_a [NREQ];
    logic [wd-1:0]  w_b [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign w_a[g] = req_a[g*wd +: wd];
        assign w_b[g] = req_b[g*wd +: wd];
    end

    assign w_win   = IDW'(rr_pick(NREQ_MAX'(req_valid), 3'(r_last), NREQ));
    assign w_grant = (r_state == IDLE) && (|req_valid);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|req_valid)             w_next = EXEC;
            EXEC:                                w_next = RESP;
            RESP:    if (rsp_valid && rsp_ready) w_next = IDLE;
            default:                             w_next = IDLE;
        endcase
    end

    // Operands only load on a grant, so they stay frozen through EXEC and RESP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_last   <= IDW'(NREQ - 1);
            r_rsp_id <= '0;
            r_op_a   <= '0;
            r_op_b   <= '0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_op_a   <= w_a[w_win];
                r_op_b   <= w_b[w_win];
                r_last   <= w_win;
                r_rsp_id <= w_win;
            end
        end
    end

    // Acceptance is visible in the IDLE cycle that ends in the grant edge; held off during reset.
    always_comb begin
        req_ready = '0;
        if (w_grant && reset) req_ready[w_win] = 1'b1;
    end

    calc #(
        .wd   (wd),
        .init (0)
    ) u_calc (
        .clk   (clk),
        .reset (reset),
        .I0    (r_op_a),
        .I1    (r_op_b),
        .O     (w_calc_o)
    );

    assign rsp_valid = (r_state == RESP);
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = w_calc_o;
    assign busy      = (r_state != IDLE);

endmodule
